// File: rtl/rtc_bcd_core_pkg.sv
// rtl/rtc_bcd_core_pkg.sv - shared BCD limits, time struct and hour/validation helpers
// Contents:
//   BCD_*_MAX   packed-BCD rollover limits for seconds, minutes and hours
//   DOW_MIN/MAX day-of-week range, 1..7
//   bcd_time_t  packed {hh, mm, ss} time record, 24 h packed BCD
//   bcd_field_ok     true when both nibbles are decimal and the value is <= limit
//   bcd_hour_12h     24 h BCD hour to 12 h BCD display hour
package rtc_bcd_core_pkg;

    localparam logic [7:0] BCD_SS_MAX  = 8'h59;
    localparam logic [7:0] BCD_MM_MAX  = 8'h59;
    localparam logic [7:0] BCD_HH_MAX  = 8'h23;
    localparam logic [7:0] BCD_HH_NOON = 8'h12;
    localparam logic [2:0] DOW_MIN     = 3'd1;
    localparam logic [2:0] DOW_MAX     = 3'd7;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } bcd_time_t;

    // Once both nibbles are known to be decimal, a plain unsigned compare
    // against a BCD limit orders the same way as the decimal values.
    function automatic logic bcd_field_ok(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    // 00 -> 12, 01..12 unchanged, 13..23 -> 01..11, done nibble-wise so no
    // binary round trip is needed. Only legal 24 h values ever reach this.
    function automatic logic [7:0] bcd_hour_12h(input logic [7:0] h24);
        logic [3:0] hi;
        logic [3:0] lo;
        logic [7:0] res;
        hi = h24[7:4];
        lo = h24[3:0];
        if (h24 == 8'h00) begin
            res = BCD_HH_NOON;
        end else if (h24 <= BCD_HH_NOON) begin
            res = h24;
        end else if (hi == 4'd1) begin
            res = {4'd0, lo - 4'd2};          // 13..19 -> 01..07
        end else if (lo <= 4'd1) begin
            res = {4'd0, lo + 4'd8};          // 20..21 -> 08..09
        end else begin
            res = {4'd1, lo - 4'd2};          // 22..23 -> 10..11
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit_pair_inc.sv
// rtl/bcd_digit_pair_inc.sv - two-digit packed BCD incrementer with rollover and carry
// Ports:
//   val       current packed BCD value (assumed legal, <= MAX_VAL)
//   inc_in    increment request (carry-in from the less significant pair)
//   val_next  value after the optional increment
//   carry_out high when the increment rolled MAX_VAL over to 00
module bcd_digit_pair_inc #(
    parameter logic [7:0] MAX_VAL = 8'h59
) (
    input  logic [7:0] val,
    input  logic       inc_in,
    output logic [7:0] val_next,
    output logic       carry_out
);

    always_comb begin
        val_next  = val;
        carry_out = 1'b0;
        if (inc_in) begin
            if (val == MAX_VAL) begin
                val_next  = 8'h00;
                carry_out = 1'b1;
            end else if (val[3:0] == 4'd9) begin
                val_next = {val[7:4] + 4'd1, 4'd0};
            end else begin
                val_next = {val[7:4], val[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/rtc_bcd_core.sv
// rtl/rtc_bcd_core.sv - BCD real-time clock with day of week, load validation and alarms
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   tick_1hz                   one-cycle advance strobe
//   set_en                     freezes counting while high
//   set_load, set_hh/mm/ss,    one-cycle load of a 24 h BCD time and day of week;
//   set_dow                    illegal values are rejected with load_err
//   mode_12h                   display select, 1 = 12 h, 0 = 24 h (display only)
//   alarm_wr, alarm_idx,       write one alarm channel (hh:mm in 24 h BCD, enable)
//   alarm_hh/mm, alarm_on
//   hh, mm, ss, pm, dow        displayed time, afternoon flag, day of week
//   day_wrap                   pulse in the first cycle showing 00:00:00
//   alarm_hit                  per-channel pulse in the first cycle showing hh:mm:00
//   load_err                   pulse the cycle after a rejected load
module rtc_bcd_core
    import rtc_bcd_core_pkg::*;
#(
    parameter int ALARM_N = 2,
    parameter int AIDX_W  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic               set_en,
    input  logic               set_load,
    input  logic [7:0]         set_hh,
    input  logic [7:0]         set_mm,
    input  logic [7:0]         set_ss,
    input  logic [2:0]         set_dow,
    input  logic               mode_12h,
    input  logic               alarm_wr,
    input  logic [AIDX_W-1:0]  alarm_idx,
    input  logic [7:0]         alarm_hh,
    input  logic [7:0]         alarm_mm,
    input  logic               alarm_on,
    output logic [7:0]         hh,
    output logic [7:0]         mm,
    output logic [7:0]         ss,
    output logic               pm,
    output logic [2:0]         dow,
    output logic               day_wrap,
    output logic [ALARM_N-1:0] alarm_hit,
    output logic               load_err
);

    bcd_time_t          cur_q;
    bcd_time_t          nxt;
    logic [2:0]         dow_q;
    logic [2:0]         dow_nxt;
    logic [7:0]         nxt_hh;
    logic [7:0]         nxt_mm;
    logic [7:0]         nxt_ss;
    logic               ss_carry;
    logic               mm_carry;
    logic               hh_carry;
    logic               adv;
    logic               load_ok;
    logic               day_wrap_q;
    logic               load_err_q;
    logic [ALARM_N-1:0] alarm_hit_q;
    logic [ALARM_N-1:0] hit_nxt;

    logic [7:0]         alm_hh_q [ALARM_N];
    logic [7:0]         alm_mm_q [ALARM_N];
    logic [ALARM_N-1:0] alm_en_q;

    // A load in the same cycle swallows the tick entirely.
    assign adv = tick_1hz & ~set_en & ~set_load;

    bcd_digit_pair_inc #(.MAX_VAL(BCD_SS_MAX)) u_inc_ss (
        .val       (cur_q.ss),
        .inc_in    (adv),
        .val_next  (nxt_ss),
        .carry_out (ss_carry)
    );

    bcd_digit_pair_inc #(.MAX_VAL(BCD_MM_MAX)) u_inc_mm (
        .val       (cur_q.mm),
        .inc_in    (ss_carry),
        .val_next  (nxt_mm),
        .carry_out (mm_carry)
    );

    bcd_digit_pair_inc #(.MAX_VAL(BCD_HH_MAX)) u_inc_hh (
        .val       (cur_q.hh),
        .inc_in    (mm_carry),
        .val_next  (nxt_hh),
        .carry_out (hh_carry)
    );

    assign nxt = '{hh: nxt_hh, mm: nxt_mm, ss: nxt_ss};

    always_comb begin
        dow_nxt = dow_q;
        if (hh_carry) begin
            dow_nxt = (dow_q == DOW_MAX) ? DOW_MIN : dow_q + 3'd1;
        end
    end

    assign load_ok = bcd_field_ok(set_hh, BCD_HH_MAX) &&
                     bcd_field_ok(set_mm, BCD_MM_MAX) &&
                     bcd_field_ok(set_ss, BCD_SS_MAX) &&
                     (set_dow >= DOW_MIN) && (set_dow <= DOW_MAX);

    // Matches are taken against the incremented value and the alarm registers
    // as they stand before this edge, so a coinciding alarm write only counts
    // from the next cycle on. Alarm contents are compared raw, unchecked.
    always_comb begin
        hit_nxt = '0;
        for (int i = 0; i < ALARM_N; i++) begin
            hit_nxt[i] = adv && alm_en_q[i] && (nxt.ss == 8'h00) &&
                         (nxt.mm == alm_mm_q[i]) && (nxt.hh == alm_hh_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q       <= '0;
            dow_q       <= DOW_MIN;
            day_wrap_q  <= 1'b0;
            load_err_q  <= 1'b0;
            alarm_hit_q <= '0;
        end else begin
            day_wrap_q  <= adv & hh_carry;
            load_err_q  <= set_load & ~load_ok;
            alarm_hit_q <= hit_nxt;
            if (set_load) begin
                if (load_ok) begin
                    cur_q <= '{hh: set_hh, mm: set_mm, ss: set_ss};
                    dow_q <= set_dow;
                end
            end else if (adv) begin
                cur_q <= nxt;
                dow_q <= dow_nxt;
            end
        end
    end

    // Indices with no matching channel simply select nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ALARM_N; i++) begin
                alm_hh_q[i] <= 8'h00;
                alm_mm_q[i] <= 8'h00;
            end
            alm_en_q <= '0;
        end else if (alarm_wr) begin
            for (int i = 0; i < ALARM_N; i++) begin
                if (alarm_idx == AIDX_W'(i)) begin
                    alm_hh_q[i] <= alarm_hh;
                    alm_mm_q[i] <= alarm_mm;
                    alm_en_q[i] <= alarm_on;
                end
            end
        end
    end

    assign hh        = mode_12h ? bcd_hour_12h(cur_q.hh) : cur_q.hh;
    assign mm        = cur_q.mm;
    assign ss        = cur_q.ss;
    assign pm        = (cur_q.hh >= BCD_HH_NOON);
    assign dow       = dow_q;
    assign day_wrap  = day_wrap_q;
    assign alarm_hit = alarm_hit_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_rtc_bcd_core.sv
// tb/tb_rtc_bcd_core.sv - self-checking bench for rtc_bcd_core against a seconds-of-day model
module tb_rtc_bcd_core;

    localparam int ALARM_N = 3;
    localparam int AIDX_W  = 2;

    logic               clk;
    logic               rst_n;
    logic               tick_1hz;
    logic               set_en;
    logic               set_load;
    logic [7:0]         set_hh;
    logic [7:0]         set_mm;
    logic [7:0]         set_ss;
    logic [2:0]         set_dow;
    logic               mode_12h;
    logic               alarm_wr;
    logic [AIDX_W-1:0]  alarm_idx;
    logic [7:0]         alarm_hh;
    logic [7:0]         alarm_mm;
    logic               alarm_on;
    logic [7:0]         hh;
    logic [7:0]         mm;
    logic [7:0]         ss;
    logic               pm;
    logic [2:0]         dow;
    logic               day_wrap;
    logic [ALARM_N-1:0] alarm_hit;
    logic               load_err;

    rtc_bcd_core #(.ALARM_N(ALARM_N), .AIDX_W(AIDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .set_en    (set_en),
        .set_load  (set_load),
        .set_hh    (set_hh),
        .set_mm    (set_mm),
        .set_ss    (set_ss),
        .set_dow   (set_dow),
        .mode_12h  (mode_12h),
        .alarm_wr  (alarm_wr),
        .alarm_idx (alarm_idx),
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .alarm_on  (alarm_on),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .pm        (pm),
        .dow       (dow),
        .day_wrap  (day_wrap),
        .alarm_hit (alarm_hit),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: time of day as seconds since midnight.
    int                 secs;
    int                 mdow;
    logic [7:0]         a_hh [ALARM_N];
    logic [7:0]         a_mm [ALARM_N];
    logic               a_en [ALARM_N];
    logic               exp_wrap;
    logic               exp_lerr;
    logic [ALARM_N-1:0] exp_hit;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic field_ok(input logic [7:0] b, input int lim);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (from_bcd(b) <= lim);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        secs     = 0;
        mdow     = 1;
        exp_wrap = 1'b0;
        exp_lerr = 1'b0;
        exp_hit  = '0;
        for (int i = 0; i < ALARM_N; i++) begin
            a_hh[i] = 8'h00;
            a_mm[i] = 8'h00;
            a_en[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        int h;
        int dh;
        h  = secs / 3600;
        dh = h;
        if (mode_12h) dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        check({tag, ".hh"},   32'(hh),        32'(to_bcd(dh)));
        check({tag, ".mm"},   32'(mm),        32'(to_bcd((secs / 60) % 60)));
        check({tag, ".ss"},   32'(ss),        32'(to_bcd(secs % 60)));
        check({tag, ".pm"},   32'(pm),        32'(h >= 12));
        check({tag, ".dow"},  32'(dow),       32'(mdow));
        check({tag, ".wrap"}, 32'(day_wrap),  32'(exp_wrap));
        check({tag, ".hit"},  32'(alarm_hit), 32'(exp_hit));
        check({tag, ".lerr"}, 32'(load_err),  32'(exp_lerr));
    endtask

    // Apply the currently driven inputs for one clock, advance the model, check.
    task automatic run_cycle(input string tag);
        exp_wrap = 1'b0;
        exp_lerr = 1'b0;
        exp_hit  = '0;
        if (set_load) begin
            if (field_ok(set_hh, 23) && field_ok(set_mm, 59) && field_ok(set_ss, 59) &&
                set_dow >= 3'd1 && set_dow <= 3'd7) begin
                secs = from_bcd(set_hh) * 3600 + from_bcd(set_mm) * 60 + from_bcd(set_ss);
                mdow = int'(set_dow);
            end else begin
                exp_lerr = 1'b1;
            end
        end else if (tick_1hz && !set_en) begin
            secs = (secs + 1) % 86400;
            if (secs == 0) begin
                exp_wrap = 1'b1;
                mdow     = (mdow % 7) + 1;
            end
            for (int i = 0; i < ALARM_N; i++) begin
                if (a_en[i] && (secs % 60 == 0) && to_bcd(secs / 3600) == a_hh[i] &&
                    to_bcd((secs / 60) % 60) == a_mm[i]) exp_hit[i] = 1'b1;
            end
        end
        if (alarm_wr && int'(alarm_idx) < ALARM_N) begin
            a_hh[alarm_idx] = alarm_hh;
            a_mm[alarm_idx] = alarm_mm;
            a_en[alarm_idx] = alarm_on;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_load(input string tag, input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input logic [2:0] d);
        set_load = 1'b1;
        set_hh   = h;
        set_mm   = m;
        set_ss   = s;
        set_dow  = d;
        run_cycle(tag);
        set_load = 1'b0;
    endtask

    task automatic do_tick(input string tag);
        tick_1hz = 1'b1;
        run_cycle(tag);
        tick_1hz = 1'b0;
    endtask

    task automatic wr_alarm(input logic [AIDX_W-1:0] idx, input logic [7:0] h,
                            input logic [7:0] m, input logic on);
        alarm_wr  = 1'b1;
        alarm_idx = idx;
        alarm_hh  = h;
        alarm_mm  = m;
        alarm_on  = on;
        run_cycle("alarm_wr");
        alarm_wr  = 1'b0;
    endtask

    int picks [4] = '{0, 1439, 450, 61};

    initial begin
        int t;
        rst_n     = 1'b0;
        tick_1hz  = 1'b0;
        set_en    = 1'b0;
        set_load  = 1'b0;
        set_hh    = 8'h00;
        set_mm    = 8'h00;
        set_ss    = 8'h00;
        set_dow   = 3'd1;
        mode_12h  = 1'b0;
        alarm_wr  = 1'b0;
        alarm_idx = '0;
        alarm_hh  = 8'h00;
        alarm_mm  = 8'h00;
        alarm_on  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.dow_const", 32'(dow), 32'd1);
        rst_n = 1'b1;
        run_cycle("idle0");

        // Midnight rollover with day-of-week wrap.
        do_load("ld235959", 8'h23, 8'h59, 8'h59, 3'd7);
        do_tick("wrap");
        check("wrap.const_hh", 32'(hh), 32'h00);
        check("wrap.const_dow", 32'(dow), 32'd1);
        check("wrap.const_pulse", 32'(day_wrap), 32'd1);
        run_cycle("wrap_end");

        // Rejected loads leave time untouched.
        do_load("bad_ss", 8'h12, 8'h34, 8'h5A, 3'd3);
        check("bad_ss.const_lerr", 32'(load_err), 32'd1);
        check("bad_ss.const_mm", 32'(mm), 32'h00);
        do_load("bad_hh", 8'h24, 8'h00, 8'h00, 3'd3);
        do_load("bad_dow", 8'h10, 8'h00, 8'h00, 3'd0);
        run_cycle("lerr_end");

        // 12 h display.
        do_load("ld0015", 8'h00, 8'h15, 8'h00, 3'd2);
        mode_12h = 1'b1;
        #1;
        check_all("m12_0015");
        check("m12_0015.const_hh", 32'(hh), 32'h12);
        do_load("ld1305", 8'h13, 8'h05, 8'h00, 3'd2);
        check("m12_1305.const_hh", 32'(hh), 32'h01);
        check("m12_1305.const_pm", 32'(pm), 32'd1);
        mode_12h = 1'b0;
        #1;
        check_all("m24_1305");
        check("m24_1305.const_hh", 32'(hh), 32'h13);

        // Alarm reached by tick versus by load.
        wr_alarm(2'd0, 8'h07, 8'h30, 1'b1);
        do_load("ld072959", 8'h07, 8'h29, 8'h59, 3'd4);
        do_tick("alm0");
        check("alm0.const_hit", 32'(alarm_hit), 32'b001);
        run_cycle("alm0_end");
        do_load("ld073000", 8'h07, 8'h30, 8'h00, 3'd4);
        run_cycle("alm0_noload");

        // Load beats a simultaneous tick.
        tick_1hz = 1'b1;
        do_load("ld_tick", 8'h10, 8'h00, 8'h00, 3'd5);
        tick_1hz = 1'b0;
        check("ld_tick.const_ss", 32'(ss), 32'h00);

        // set_en freezes counting.
        set_en = 1'b1;
        do_tick("frozen");
        set_en = 1'b0;
        do_tick("unfrozen");

        // Out-of-range channel index is ignored.
        wr_alarm(2'd3, 8'h11, 8'h00, 1'b1);
        do_load("ld105959", 8'h10, 8'h59, 8'h59, 3'd5);
        do_tick("idx3");
        check("idx3.const_hit", 32'(alarm_hit), 32'b000);

        // Write coinciding with a match uses the old value; then twin channels.
        wr_alarm(2'd1, 8'h08, 8'h00, 1'b1);
        do_load("ld075959", 8'h07, 8'h59, 8'h59, 3'd5);
        tick_1hz  = 1'b1;
        alarm_wr  = 1'b1;
        alarm_idx = 2'd1;
        alarm_hh  = 8'h09;
        alarm_mm  = 8'h00;
        alarm_on  = 1'b1;
        run_cycle("wr_coincide");
        tick_1hz  = 1'b0;
        alarm_wr  = 1'b0;
        check("wr_coincide.const_hit", 32'(alarm_hit), 32'b010);
        wr_alarm(2'd2, 8'h09, 8'h00, 1'b1);
        do_load("ld085959", 8'h08, 8'h59, 8'h59, 3'd5);
        do_tick("twin");
        check("twin.const_hit", 32'(alarm_hit), 32'b110);

        // Reset landing between a tick strobe and its clock edge.
        do_load("ld_prerst", 8'h07, 8'h29, 8'h59, 3'd6);
        tick_1hz = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        tick_1hz = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_tick("post_rst_tick");
        check("post_rst.const_ss", 32'(ss), 32'h01);
        wr_alarm(2'd0, 8'h00, 8'h00, 1'b0);
        do_load("ld_post", 8'h07, 8'h29, 8'h59, 3'd1);
        do_tick("post_rst_noalm");
        check("post_rst.const_hit", 32'(alarm_hit), 32'b000);

        // Randomized traffic around alarm and midnight boundaries.
        for (int n = 0; n < 400; n++) begin
            mode_12h = 1'($urandom % 2);
            set_en   = ($urandom % 10) == 0;
            tick_1hz = ($urandom % 10) < 7;
            set_load = ($urandom % 20) == 0;
            alarm_wr = ($urandom % 25) == 0;
            if (set_load) begin
                if ($urandom % 4 == 0) begin
                    set_hh  = 8'($urandom);
                    set_mm  = 8'($urandom);
                    set_ss  = 8'($urandom);
                    set_dow = 3'($urandom);
                end else begin
                    t = (picks[$urandom % 4] * 60 - int'($urandom % 3) + 86400) % 86400;
                    set_hh  = to_bcd(t / 3600);
                    set_mm  = to_bcd((t / 60) % 60);
                    set_ss  = to_bcd(t % 60);
                    set_dow = 3'($urandom_range(1, 7));
                end
            end
            if (alarm_wr) begin
                t = picks[$urandom % 4];
                alarm_idx = AIDX_W'($urandom);
                alarm_hh  = to_bcd(t / 60);
                alarm_mm  = to_bcd(t % 60);
                alarm_on  = ($urandom % 4) != 0;
            end
            run_cycle("rand");
            set_load = 1'b0;
            alarm_wr = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtc_bcd_core.md
RTC_BCD_CORE -- requirements
Module: rtc_bcd_core

Interface
REQ-001 SHALL have parameter ALARM_N, default 2: number of independent alarm channels, legal range 1..8.
REQ-002 SHALL have parameter AIDX_W, default 1: alarm index width, equal to max(1, clog2(ALARM_N)).
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port tick_1hz, input, 1 bit: one-cycle 1 Hz advance strobe.
REQ-006 SHALL have port set_en, input, 1 bit: high freezes counting.
REQ-007 SHALL have port set_load, input, 1 bit: one-cycle load strobe.
REQ-008 SHALL have ports set_hh, set_mm and set_ss, input, 8 bits each: packed BCD load values; set_hh is always in 24 h form.
REQ-009 SHALL have port set_dow, input, 3 bits: day-of-week load value, 1..7.
REQ-010 SHALL have port mode_12h, input, 1 bit: display format select, 1 = 12 h, 0 = 24 h.
REQ-011 SHALL have port alarm_wr, input, 1 bit: alarm register write strobe.
REQ-012 SHALL have port alarm_idx, input, AIDX_W bits: alarm channel to write.
REQ-013 SHALL have ports alarm_hh and alarm_mm, input, 8 bits each: alarm time, BCD, 24 h form.
REQ-014 SHALL have port alarm_on, input, 1 bit: enable value written with the alarm.
REQ-015 SHALL have ports hh, mm and ss, output, 8 bits each: displayed BCD time.
REQ-016 SHALL have port pm, output, 1 bit: high when the internal hour is 12..23, in either display mode.
REQ-017 SHALL have port dow, output, 3 bits: current day of week.
REQ-018 SHALL have port day_wrap, output, 1 bit: one-cycle pulse on 23:59:59 -> 00:00:00.
REQ-019 SHALL have port alarm_hit, output, ALARM_N bits: per-channel one-cycle match pulse.
REQ-020 SHALL have port load_err, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-021 SHALL hold internal time as 24 h packed BCD; increment SHALL be BCD carry ss -> mm -> hh -> dow, with x9 -> (x+1)0, 59 -> 00, 23 -> 00 and dow 7 -> 1.
REQ-022 SHALL advance exactly once per tick_1hz when set_en=0 and set_load=0; new time SHALL be visible on outputs the cycle after the tick (1-cycle latency).
REQ-023 set_load SHALL take priority over a simultaneous tick; that tick SHALL be discarded and no day_wrap or alarm_hit generated.
REQ-024 SHALL validate a load: all nibbles <= 9, hh <= 23, mm <= 59, ss <= 59 and dow in 1..7; if invalid, all state SHALL be unchanged and load_err SHALL pulse the next cycle.
REQ-025 set_load SHALL be honoured regardless of set_en.
REQ-026 In 12 h mode, hh SHALL display 00 -> 12, 01..12 unchanged, and 13..23 -> 01..11; mode_12h SHALL affect display only, never internal state.
REQ-027 SHALL provide display conversion as combinational logic from registers, so a mode_12h change is visible in the same cycle.
REQ-028 alarm_hit[i] SHALL pulse in the first cycle the outputs show hh:mm:00 matching channel i, with channel i enabled, reached by a tick increment only.
REQ-029 Multiple channels with identical settings SHALL pulse simultaneously.
REQ-030 An alarm write coinciding with a matching increment SHALL compare against the old alarm value; the new value SHALL take effect the following cycle.
REQ-031 alarm_wr with alarm_idx >= ALARM_N SHALL be ignored; alarm values SHALL NOT be range-checked.
REQ-032 day_wrap SHALL pulse in the same cycle the outputs first show 00:00:00.

Reset
REQ-033 rst_n low SHALL asynchronously force time to 00:00:00, dow=1, all alarms 00:00 disabled, and day_wrap, alarm_hit and load_err to 0.
REQ-034 Reset mid-load or mid-tick SHALL discard the pending operation; the first tick after release SHALL advance from 00:00:00.

Structure
REQ-035 A shared package SHALL hold BCD limit constants (59, 23, 7) and a packed-struct type for {hh, mm, ss}.
REQ-036 One sub-module, bcd_digit_pair_inc (packed BCD increment with a parametrised max value and a carry-out), SHALL be instantiated for ss, mm and hh.

Verification
REQ-037 Load 23:59:59, dow=7, then tick: outputs 00:00:00, dow=1, and day_wrap high for 1 cycle.
REQ-038 Load 12:34:5A: load_err pulses; time stays at its prior value.
REQ-039 Internal 00:15:00 with mode_12h=1: display 12:15, pm=0. Internal 13:05:00: display 01:05, pm=1; switching mode_12h=0 shows 13:05 in the same cycle.
REQ-040 Alarm 0 = 07:30 enabled, load 07:29:59, tick: alarm_hit=01 for 1 cycle. Loading 07:30:00 directly instead: no alarm_hit.
REQ-041 set_load and tick in the same cycle with 10:00:00: result 10:00:00 exactly, no increment.
REQ-042 Assert rst_n low between a tick and its update: all outputs reset, alarms disabled, and no pulses after release.
